compressor_sched: RTL
=====================

# compressor_sched

Round-robin scheduler that shares one dual-port compression lookup table between NCH stereo sample sources. Each source presents a 12-bit signed L/R pair with a req/ack handshake. The block sign-folds the samples into table addresses and drives both LUT ports (A = left, B = right). It then unfolds the table outputs into 16-bit signed samples, tagged with the source channel. It sits between the sound generators and the output mixer, replacing one compressor instance per source.

## Interface
- NCH, default 4: number of stereo requesters; valid range 2..8.
- CW, default $clog2(NCH): channel index width (derived, not overridden).
- DECAY_DIV, default 4096: peak-meter decay period in clk cycles (used only with COMP_PEAK_EN).

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NCH  per-channel request; data held stable while high
- in_l  in  NCH*12  left samples, channel i at [12i+11:12i], signed
- in_r  in  NCH*12  right samples, same packing
- ack  out  NCH  one-hot grant; sample captured in the cycle ack[i] is high
- lut_addr_a  out  11  LUT port A address (left)
- lut_addr_b  out  11  LUT port B address (right)
- lut_q_a  in  15  LUT port A data; registered RAM, 1-cycle read latency
- lut_q_b  in  15  LUT port B data
- out_l  out  16  compressed left sample, signed
- out_r  out  16  compressed right sample, signed
- out_ch  out  CW  channel index of out_l/out_r
- out_valid  out  1  one-cycle strobe, outputs valid
- peak_sel  in  CW  peak-meter channel select (COMP_PEAK_EN only)
- peak_out  out  15  peak magnitude of the selected channel (COMP_PEAK_EN only)

## Operation
- Arbiter: registered pointer ptr. ack is combinational from req and ptr: the first requesting channel, searching ptr, ptr+1, ... (mod NCH), gets the grant. At most one ack bit is high per cycle.
- On a grant to channel g: ptr <= (g+1) mod NCH. With no request, ptr holds.
- A requester that keeps req high after ack is re-served in its next round-robin slot; there is no back-to-back starvation.
- Stage 1 (edge ending the ack cycle) registers:
  - the sign bits sl = in_l[g][11] and sr = in_r[g][11];
  - the channel g and a valid bit;
  - lut_addr_a = {11{sl}} ^ in_l[g][10:0] and lut_addr_b = {11{sr}} ^ in_r[g][10:0].
- Stage 2: the RAM returns q; the block forwards sl, sr, channel and valid unchanged.
- Stage 3 registers:
  - out_l = {sl, {15{sl}} ^ lut_q_a} and out_r = {sr, {15{sr}} ^ lut_q_b};
  - out_ch, and out_valid = stage-2 valid.
- With no grant, the addresses hold their previous values, valid bits are 0 and out_l/out_r/out_ch hold.
- Reset mid-pipeline: all in-flight samples are discarded and no out_valid is produced for them.

## Timing
- ack in cycle T, then addresses valid in T+1, q valid in T+2, out_valid high in T+3 (latency 3). Throughput is one stereo pair per cycle.
- Reset values: ptr=0, ack=0 (combinational, but forced low while rst is high), lut_addr_a/b=0, pipeline valids=0, out_l=out_r=0, out_ch=0, out_valid=0, peak_out=0, all peaks 0, decay counter 0.
- First cycle after rst deasserts: arbitration starts from channel 0.

## Configuration
- COMP_PEAK_EN defined: the block adds per-channel 15-bit peak registers, peak[ch].
  - Update: on out_valid, peak[out_ch] <= max(peak[out_ch], lut_q_a, lut_q_b), using the folded magnitudes captured at stage 3.
  - Decay: a counter wraps every DECAY_DIV cycles; on the wrap, every peak decrements by 1, saturating at 0.
  - Update and decay in the same cycle on the same channel: the update wins, with no decrement.
  - peak_out = peak[peak_sel], registered, so it follows peak_sel with 1 cycle of latency.
- COMP_PEAK_EN undefined: no peak logic. peak_out is tied to 0 and peak_sel is ignored.

## Test plan
- LUT model q=addr<<4, with a 1-cycle register. Channel 0 requests in_l=12'h7FF, in_r=12'h800 → ack[0] in T; lut_addr_a=0x7FF, lut_addr_b=0x7FF in T+1; in T+3 out_l=16'h7FF0, out_r=16'h800F, out_ch=0, out_valid=1.
- req=4'b1111 held for 8 cycles → ack sequence 0,1,2,3,0,1,2,3; out_ch follows 3 cycles later; out_valid continuous.
- req toggles to 4'b1010 with ptr=0 → grants alternate 1,3,1,3; channels 0 and 2 never acked.
- Three back-to-back grants, then rst asserted in the cycle after the last ack → no out_valid pulses afterwards; all outputs 0; next grant after release goes to channel 0.
- Zero sample 12'h000 / 12'hFFF → out_l=16'h0000 and out_r=16'hFFFF (sign-fold symmetry).
- COMP_PEAK_EN with DECAY_DIV=8: channel 2 produces q=0x0100 → peak_out=0x0100 (peak_sel=2) and decreases by 1 every 8 cycles. A new sample landing on a decay tick holds the new maximum.

Source files
------------

// File: rtl/compressor_sched_if.sv
// Signal bundle for compressor_sched: requester handshake and samples, shared LUT ports,
// compressed output stream and the optional peak meter.
interface compressor_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    ack;
  logic [NCH*12-1:0] in_l;
  logic [NCH*12-1:0] in_r;
  logic [10:0]       lut_addr_a;
  logic [10:0]       lut_addr_b;
  logic [14:0]       lut_q_a;
  logic [14:0]       lut_q_b;
  logic [15:0]       out_l;
  logic [15:0]       out_r;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic [CW-1:0]     peak_sel;
  logic [14:0]       peak_out;

  modport master (
    output req, in_l, in_r, lut_q_a, lut_q_b, peak_sel,
    input  ack, lut_addr_a, lut_addr_b, out_l, out_r, out_ch, out_valid, peak_out
  );

  modport slave (
    input  req, in_l, in_r, lut_q_a, lut_q_b, peak_sel,
    output ack, lut_addr_a, lut_addr_b, out_l, out_r, out_ch, out_valid, peak_out
  );
endinterface

// File: rtl/compressor_sched.sv
// Round-robin scheduler sharing one dual-port compression LUT between NCH stereo sources.
// Optional per-channel peak meter enabled by defining COMP_PEAK_EN.
module compressor_sched #(
  parameter int NCH       = 4,
  parameter int DECAY_DIV = 4096
) (
  input logic               clk,
  input logic               rst,
  compressor_sched_if.slave bus
);
  localparam int CW = $clog2(NCH);

  logic [11:0]   ch_l [NCH];
  logic [11:0]   ch_r [NCH];
  logic [CW-1:0] ptr;
  logic [CW-1:0] gnt_ch;
  logic [CW-1:0] idx;
  logic          gnt;
  logic [11:0]   sel_l;
  logic [11:0]   sel_r;

  logic          s1_valid;
  logic [CW-1:0] s1_ch;
  logic          s1_sl;
  logic          s1_sr;
  logic          s2_valid;
  logic [CW-1:0] s2_ch;
  logic          s2_sl;
  logic          s2_sr;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign ch_l[i] = bus.in_l[12*i +: 12];
    assign ch_r[i] = bus.in_r[12*i +: 12];
  end

  // First requester at or after ptr, wrapping; suppressed while reset is held.
  always_comb begin
    gnt    = 1'b0;
    gnt_ch = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = CW'((32'(ptr) + k) % NCH);
      if (!gnt && bus.req[idx]) begin
        gnt    = 1'b1;
        gnt_ch = idx;
      end
    end
    if (rst) gnt = 1'b0;
  end

  assign bus.ack = gnt ? (NCH'(1) << gnt_ch) : '0;
  assign sel_l   = ch_l[gnt_ch];
  assign sel_r   = ch_r[gnt_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      s1_valid       <= 1'b0;
      s1_ch          <= '0;
      s1_sl          <= 1'b0;
      s1_sr          <= 1'b0;
      s2_valid       <= 1'b0;
      s2_ch          <= '0;
      s2_sl          <= 1'b0;
      s2_sr          <= 1'b0;
      bus.lut_addr_a <= '0;
      bus.lut_addr_b <= '0;
      bus.out_l      <= '0;
      bus.out_r      <= '0;
      bus.out_ch     <= '0;
      bus.out_valid  <= 1'b0;
    end else begin
      s1_valid <= gnt;
      if (gnt) begin
        ptr            <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
        s1_ch          <= gnt_ch;
        s1_sl          <= sel_l[11];
        s1_sr          <= sel_r[11];
        bus.lut_addr_a <= {11{sel_l[11]}} ^ sel_l[10:0];
        bus.lut_addr_b <= {11{sel_r[11]}} ^ sel_r[10:0];
      end
      // Stage 2 waits out the RAM read so sign/channel line up with lut_q.
      s2_valid      <= s1_valid;
      s2_ch         <= s1_ch;
      s2_sl         <= s1_sl;
      s2_sr         <= s1_sr;
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_l  <= {s2_sl, {15{s2_sl}} ^ bus.lut_q_a};
        bus.out_r  <= {s2_sr, {15{s2_sr}} ^ bus.lut_q_b};
        bus.out_ch <= s2_ch;
      end
    end
  end

`ifdef COMP_PEAK_EN
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [DW-1:0] dcnt;
  logic          tick;
  logic [14:0]   qa3;
  logic [14:0]   qb3;
  logic [14:0]   qmax;
  logic [14:0]   peak [NCH];

  assign tick = (dcnt == DW'(DECAY_DIV - 1));
  assign qmax = (qa3 > qb3) ? qa3 : qb3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt         <= '0;
      qa3          <= '0;
      qb3          <= '0;
      bus.peak_out <= '0;
      for (int unsigned i = 0; i < NCH; i++) peak[i] <= '0;
    end else begin
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (s2_valid) begin
        qa3 <= bus.lut_q_a;
        qb3 <= bus.lut_q_b;
      end
      // A channel being updated skips the decay step on the same edge.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (bus.out_valid && bus.out_ch == CW'(i))
          peak[i] <= (qmax > peak[i]) ? qmax : peak[i];
        else if (tick && peak[i] != '0)
          peak[i] <= peak[i] - 1'b1;
      end
      bus.peak_out <= (32'(bus.peak_sel) < NCH) ? peak[bus.peak_sel] : '0;
    end
  end
`else
  localparam int unused_decay_div = DECAY_DIV;
  logic unused_peak_sel;
  assign unused_peak_sel = ^bus.peak_sel;
  assign bus.peak_out    = '0;
`endif
endmodule
